// File: rtl/input_flit_buffer_if.sv
// rtl/input_flit_buffer_if.sv - flit push stream in, valid/ready flit stream out
interface input_flit_buffer_if #(
  parameter int FLIT_WIDTH = 32
);
  // Push side: the input register stage writes every cycle and cannot be stalled.
  logic [FLIT_WIDTH-1:0] in_flit;
  logic                  in_valid;
  logic                  in_last;
  // Pop side: the head of the FIFO is offered to the switch/arbiter.
  logic [FLIT_WIDTH-1:0] out_flit;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  // Producer and consumer environment of the buffer.
  modport master (
    output in_flit, in_valid, in_last,
    input  out_flit, out_last, out_valid,
    output out_ready
  );

  // The buffer itself.
  modport slave (
    input  in_flit, in_valid, in_last,
    output out_flit, out_last, out_valid,
    input  out_ready
  );
endinterface

// File: rtl/input_flit_buffer.sv
// rtl/input_flit_buffer.sv - elastic input flit FIFO with packet-truncating overflow handling
module input_flit_buffer #(
  parameter int FLIT_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input_flit_buffer_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       overflow_err,
  input  logic                       clear_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL_LVL = FW'(DEPTH);

  // PASS: flits are stored. DROP: the rest of a packet that lost a flit is discarded.
  typedef enum logic {
    PASS = 1'b0,
    DROP = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Each entry holds {last, flit}; storage is deliberately left unreset.
  logic [FLIT_WIDTH:0] mem [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic overflow;
  logic discard;

  assign full          = (fill == FULL_LVL);
  assign bus.out_valid = (fill != '0);
  assign pop           = bus.out_valid & bus.out_ready;

  // A same-cycle pop frees the slot at full, so the write still fits.
  assign push     = bus.in_valid & (state == PASS) & (~full | pop);
  assign overflow = bus.in_valid & (state == PASS) & full & ~pop;
  // Any flit thrown away, either the overflowing one or a tail-of-packet drop.
  assign discard  = overflow | (bus.in_valid & (state == DROP));

  // Head of queue is presented straight from storage; no bypass from the input.
  assign bus.out_flit = mem[rd_ptr][FLIT_WIDTH-1:0];
  assign bus.out_last = mem[rd_ptr][FLIT_WIDTH];

  // Write accepted flits into the slot addressed by the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.in_last, bus.in_flit};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy tracks push minus pop; simultaneous push and pop cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
    end else begin
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Overflow truncation FSM: a lost non-tail flit drops everything up to the packet tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PASS;
    end else begin
      case (state)
        PASS: begin
          if (overflow && !bus.in_last) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.in_valid && bus.in_last) begin
            state <= PASS;
          end
        end
        default: state <= PASS;
      endcase
    end
  end

  // Sticky discard flag for the fault monitor; a new discard beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (discard) begin
      overflow_err <= 1'b1;
    end else if (clear_err) begin
      overflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_flit_buffer.sv
// tb/tb_input_flit_buffer.sv - directed self-checking bench for input_flit_buffer
module tb_input_flit_buffer;

  logic       clk;
  logic       rst_n;
  logic [2:0] fill;
  logic       overflow_err;
  logic       clear_err;

  int checks;
  int errors;

  input_flit_buffer_if #(.FLIT_WIDTH(32)) bus ();

  input_flit_buffer #(
    .FLIT_WIDTH(32),
    .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .fill(fill),
    .overflow_err(overflow_err),
    .clear_err(clear_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs and samples change 1 ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one flit for one cycle, then idle the input.
  task automatic push1(input logic [31:0] d, input logic last);
    bus.in_flit  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    cyc();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Pop one flit, checking the head before the edge.
  task automatic pop1(input string tag, input logic [31:0] d, input logic last);
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_flit"}, bus.out_flit, d);
    check({tag, "_last"}, {31'd0, bus.out_last}, {31'd0, last});
    cyc();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    clear_err     = 1'b0;
    bus.in_flit   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    cyc();
    cyc();
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_fill", {29'd0, fill}, 32'd0);
    check("rst_err", {31'd0, overflow_err}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Ordering with latency of one cycle into an empty FIFO
    push1(32'h11, 1'b0);
    check("ord_fill1", {29'd0, fill}, 32'd1);
    check("ord_lat", bus.out_flit, 32'h11);
    push1(32'h22, 1'b0);
    check("ord_fill2", {29'd0, fill}, 32'd2);
    push1(32'h33, 1'b1);
    check("ord_fill3", {29'd0, fill}, 32'd3);
    pop1("ord0", 32'h11, 1'b0);
    pop1("ord1", 32'h22, 1'b0);
    pop1("ord2", 32'h33, 1'b1);
    check("ord_fill0", {29'd0, fill}, 32'd0);
    check("ord_empty", {31'd0, bus.out_valid}, 32'd0);

    // Full plus simultaneous pop accepts the write
    push1(32'h41, 1'b0);
    push1(32'h42, 1'b0);
    push1(32'h43, 1'b0);
    push1(32'h44, 1'b1);
    check("full_fill", {29'd0, fill}, 32'd4);
    bus.out_ready = 1'b1;
    push1(32'h45, 1'b1);
    bus.out_ready = 1'b0;
    check("fp_fill", {29'd0, fill}, 32'd4);
    check("fp_err", {31'd0, overflow_err}, 32'd0);

    // Overflow mid-packet: whole 3-flit packet dropped
    push1(32'hB0, 1'b0);
    check("ovf_err", {31'd0, overflow_err}, 32'd1);
    check("ovf_fill0", {29'd0, fill}, 32'd4);
    push1(32'hB1, 1'b0);
    check("ovf_fill1", {29'd0, fill}, 32'd4);
    push1(32'hB2, 1'b1);
    check("ovf_fill2", {29'd0, fill}, 32'd4);
    pop1("ovf_d0", 32'h42, 1'b0);
    pop1("ovf_d1", 32'h43, 1'b0);
    pop1("ovf_d2", 32'h44, 1'b1);
    pop1("ovf_d3", 32'h45, 1'b1);
    check("ovf_drained", {29'd0, fill}, 32'd0);
    push1(32'hC0, 1'b0);
    push1(32'hC1, 1'b1);
    check("nxt_fill", {29'd0, fill}, 32'd2);
    pop1("nxt0", 32'hC0, 1'b0);
    pop1("nxt1", 32'hC1, 1'b1);

    // clear_err alone
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    check("clr_alone", {31'd0, overflow_err}, 32'd0);

    // DROP ignores free space
    push1(32'h51, 1'b0);
    push1(32'h52, 1'b0);
    push1(32'h53, 1'b0);
    push1(32'h54, 1'b1);
    push1(32'h60, 1'b0);
    check("drp_err", {31'd0, overflow_err}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (4) cyc();
    bus.out_ready = 1'b0;
    check("drp_drain", {29'd0, fill}, 32'd0);
    push1(32'h61, 1'b0);
    check("drp_fill_a", {29'd0, fill}, 32'd0);
    check("drp_valid", {31'd0, bus.out_valid}, 32'd0);
    push1(32'h62, 1'b1);
    check("drp_fill_b", {29'd0, fill}, 32'd0);
    push1(32'h63, 1'b1);
    check("drp_resume", {29'd0, fill}, 32'd1);
    pop1("drp_out", 32'h63, 1'b1);

    // Set beats clear; tail overflow stays in PASS
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    check("clr2", {31'd0, overflow_err}, 32'd0);
    push1(32'h71, 1'b0);
    push1(32'h72, 1'b0);
    push1(32'h73, 1'b0);
    push1(32'h74, 1'b1);
    clear_err = 1'b1;
    push1(32'h80, 1'b1);
    clear_err = 1'b0;
    check("set_wins", {31'd0, overflow_err}, 32'd1);
    check("set_fill", {29'd0, fill}, 32'd4);
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    check("clr3", {31'd0, overflow_err}, 32'd0);
    pop1("tail0", 32'h71, 1'b0);
    push1(32'h82, 1'b1);
    check("tail_pass", {29'd0, fill}, 32'd4);

    // Reset mid-stream with 3 entries stored and the error flag set
    push1(32'h83, 1'b1);
    check("pre_rst_err", {31'd0, overflow_err}, 32'd1);
    pop1("pre_rst", 32'h72, 1'b0);
    check("pre_rst_fill", {29'd0, fill}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("arst_fill", {29'd0, fill}, 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("arst_err", {31'd0, overflow_err}, 32'd0);
    push1(32'hA5, 1'b1);
    check("arst_valid1", {31'd0, bus.out_valid}, 32'd1);
    check("arst_flit", bus.out_flit, 32'hA5);
    check("arst_fill1", {29'd0, fill}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
